// File: rtl/pdm_decimator.sv
// pdm_decimator: receive side of the 1-bit first-order sigma-delta audio link.
// A 2nd-order CIC (two integrators, two combs) turns the bit stream back into
// unsigned PCM, one sample every 2^DECIM_LOG2 enabled clocks. `sync` realigns
// the decimation window to the transmitter and restarts the filter history.
module pdm_decimator #(
  parameter int DECIM_LOG2 = 10,
  parameter int OUT_W      = 16
) (
  input  logic             clk48,
  input  logic             rst,
  input  logic             en,
  input  logic             pdm_in,
  input  logic             sync,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             settled
);

  // Integrator / comb width: DC gain is R^2 = 2^(2*DECIM_LOG2), plus one bit
  // so full scale is representable. All arithmetic wraps modulo 2^W on purpose.
  localparam int W  = 2*DECIM_LOG2 + 1;
  localparam int SH = 2*DECIM_LOG2 - OUT_W;

  typedef logic [W-1:0] acc_t;

  // Registered state
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  acc_t                  i1_q, i1_d;
  acc_t                  i2_q, i2_d;
  acc_t                  s_prev_q, s_prev_d;
  acc_t                  c1_prev_q, c1_prev_d;
  logic [1:0]            wu_q, wu_d;
  logic [OUT_W-1:0]      sample_q, sample_d;
  logic                  valid_q, valid_d;

  // Datapath intermediates
  acc_t                  i1_nx, i2_nx;
  acc_t                  c1, c2, c2_sh;
  logic [OUT_W-1:0]      sat;
  logic                  dec_pt;

  // Integrators include the current bit; combs work on the snapshot i2_nx so
  // the window ends exactly on the cnt==R-1 cycle.
  always_comb begin
    i1_nx  = i1_q + acc_t'(pdm_in);
    i2_nx  = i2_q + i1_nx;
    c1     = i2_nx - s_prev_q;
    c2     = c1 - c1_prev_q;
    c2_sh  = c2 >> SH;
    // Only full scale (c2 = R^2) overflows OUT_W bits after the shift.
    sat    = (|c2_sh[W-1:OUT_W]) ? '1 : c2_sh[OUT_W-1:0];
    dec_pt = en && (cnt_q == '1);
  end

  // Next-state: sync clears the window and history (sample kept), en=0 freezes
  // everything, the strobe lasts a single cycle.
  always_comb begin
    cnt_d     = cnt_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    s_prev_d  = s_prev_q;
    c1_prev_d = c1_prev_q;
    wu_d      = wu_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    if (sync) begin
      cnt_d     = '0;
      i1_d      = '0;
      i2_d      = '0;
      s_prev_d  = '0;
      c1_prev_d = '0;
      wu_d      = '0;
    end else if (en) begin
      cnt_d = cnt_q + DECIM_LOG2'(1);
      i1_d  = i1_nx;
      i2_d  = i2_nx;
      if (dec_pt) begin
        s_prev_d  = i2_nx;
        c1_prev_d = c1;
        // First two decimation points only fill the comb history.
        if (wu_q == 2'd2) begin
          sample_d = sat;
          valid_d  = 1'b1;
        end else begin
          wu_d = wu_q + 2'd1;
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk48) begin
    if (rst) begin
      cnt_q     <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      s_prev_q  <= '0;
      c1_prev_q <= '0;
      wu_q      <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      s_prev_q  <= s_prev_d;
      c1_prev_q <= c1_prev_d;
      wu_q      <= wu_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign settled      = (wu_q == 2'd2);

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator: constant, alternating, sync, en-throttled
// and sigma-delta loopback streams with hand-derived expected samples.
module tb_pdm_decimator;
  localparam int D = 10;
  localparam int R = 1 << D;

  logic        clk48 = 1'b0;
  logic        rst = 1'b1, en = 1'b0, pdm_in = 1'b0, sync = 1'b0;
  logic [15:0] sample;
  logic        sample_valid, settled;

  int n_cmp = 0;
  int n_err = 0;

  pdm_decimator #(.DECIM_LOG2(D), .OUT_W(16)) dut (
    .clk48(clk48), .rst(rst), .en(en), .pdm_in(pdm_in), .sync(sync),
    .sample(sample), .sample_valid(sample_valid), .settled(settled)
  );

  always #5 clk48 = ~clk48;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sync = 1'b0; pdm_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_settled", settled, 0);
  endtask

  // mode 0: zeros, 1: ones, 2: alternating 1,0, 3: ones with en toggling 1,0.
  // Observation after iteration k is the DUT state in cycle k+1.
  task automatic run(input int n, input int mode, input logic [15:0] expv,
                     input string tag, output int nstb, output int first,
                     output int gap, output int srise);
    int prev;
    nstb = 0; first = -1; gap = 0; srise = -1; prev = -1;
    for (int k = 0; k < n; k++) begin
      sync   = 1'b0;
      en     = (mode == 3) ? (k % 2 == 0) : 1'b1;
      pdm_in = (mode == 1 || mode == 3) ? 1'b1 : (mode == 2) ? (k % 2 == 0) : 1'b0;
      tick();
      if (settled && srise < 0) srise = k + 1;
      if (sample_valid) begin
        chk(tag, sample, expv);
        if (first < 0) first = k + 1;
        else gap = k + 1 - prev;
        prev = k + 1;
        nstb++;
      end
    end
  endtask

  initial begin
    int nstb, first, gap, srise;
    int div, acc, tmp, diff, seen;
    logic synced, bitv;

    // 1: zeros; settled once two decimation points filled the history.
    do_reset();
    run(4*R, 0, 16'h0000, "zero_val", nstb, first, gap, srise);
    chk("zero_nstb", nstb, 2);
    chk("zero_first", first, 3*R);
    chk("zero_gap", gap, R);
    chk("zero_settle", srise, 2*R);

    // 2: all ones saturates to full scale.
    do_reset();
    run(5*R, 1, 16'hFFFF, "ones_val", nstb, first, gap, srise);
    chk("ones_nstb", nstb, 3);
    chk("ones_first", first, 3*R);

    // 3: 50% density decodes exactly to mid-scale.
    do_reset();
    run(5*R, 2, 16'h8000, "alt_val", nstb, first, gap, srise);
    chk("alt_nstb", nstb, 3);
    chk("alt_gap", gap, R);

    // 4: sync mid-window at cnt=500, then ones.
    run(500, 2, 16'h8000, "pre_sync_val", nstb, first, gap, srise);
    chk("pre_sync_nstb", nstb, 0);
    chk("pre_sync_settled", settled, 1);
    en = 1'b1; sync = 1'b1; pdm_in = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_settled", settled, 0);
    chk("sync_valid", sample_valid, 0);
    chk("sync_sample_hold", sample, 16'h8000);
    run(4*R, 1, 16'hFFFF, "post_sync_val", nstb, first, gap, srise);
    chk("post_sync_first", first, 3*R);
    chk("post_sync_nstb", nstb, 2);

    // 5: ones with en at 50% duty; windows stretch to 2R clocks.
    do_reset();
    run(10*R, 3, 16'hFFFF, "en_val", nstb, first, gap, srise);
    chk("en_nstb", nstb, 3);
    chk("en_first", first, 6*R - 1);
    chk("en_gap", gap, 2*R);
    chk("en_settle", srise, 4*R - 1);

    // 6: loopback from a first-order sigma-delta modulator at 0x4000,
    // sync on the first divider carry.
    do_reset();
    div = 0; acc = 0; synced = 1'b0; seen = 0;
    for (int k = 0; k < 5*R; k++) begin
      tmp    = acc + 16'h4000;
      bitv   = (tmp >= 65536);
      acc    = tmp & 16'hFFFF;
      en     = 1'b1;
      pdm_in = bitv;
      sync   = (div == R - 1) && !synced;
      if (sync) synced = 1'b1;
      div    = (div + 1) % R;
      tick();
      if (sample_valid && seen == 0) begin
        seen = 1;
        diff = int'(sample) - 16'h4000;
        if (diff < 0) diff = -diff;
        chk("loop_close", (diff <= 64), 1);
      end
    end
    sync = 1'b0;
    chk("loop_seen", seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
